// File: rtl/libv_csa_acc.sv
// rtl/libv_csa_acc.sv - carry-save burst accumulator with chunked carry-propagate resolve
// Folds (sum, carry) beats through a 4:2 compressor, then resolves K bits per cycle.
module libv_csa_acc #(
  parameter int W = 32,
  parameter int K = 8
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_s,
  input  logic [W-1:0] in_c,
  input  logic         in_last,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_sum,
  input  logic         out_rdy,
  output logic         busy
);

  localparam int NCH = W / K;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  generate
    if ((K < 1) || ((W % K) != 0)) begin : g_bad_k
      $error("libv_csa_acc: W must be a non-zero multiple of K");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_ACC     = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_OUT     = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  acc_s_q, acc_s_d;
  logic [W-1:0]  acc_c_q, acc_c_d;
  logic [W-1:0]  res_q, res_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          cy_q, cy_d;

  // Two cascaded 3:2 rows; each carry row drops its MSB so arithmetic stays mod 2^W.
  logic [W-1:0] r1_s, r1_maj, r1_c;
  logic [W-1:0] r2_s, r2_maj, r2_c;

  assign r1_s   = acc_s_q ^ acc_c_q ^ in_s;
  assign r1_maj = (acc_s_q & acc_c_q) | (acc_s_q & in_s) | (acc_c_q & in_s);
  assign r1_c   = {r1_maj[W-2:0], 1'b0};

  assign r2_s   = r1_s ^ r1_c ^ in_c;
  assign r2_maj = (r1_s & r1_c) | (r1_s & in_c) | (r1_c & in_c);
  assign r2_c   = {r2_maj[W-2:0], 1'b0};

  int           ch_base;
  logic [K-1:0] ch_s, ch_c;
  logic [K:0]   ch_sum;

  assign ch_base = int'(idx_q) * K;
  assign ch_s    = acc_s_q[ch_base +: K];
  assign ch_c    = acc_c_q[ch_base +: K];
  assign ch_sum  = {1'b0, ch_s} + {1'b0, ch_c} + {{K{1'b0}}, cy_q};

  always_comb begin
    state_d = state_q;
    acc_s_d = acc_s_q;
    acc_c_d = acc_c_q;
    res_d   = res_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    case (state_q)
      ST_ACC: begin
        if (in_vld) begin
          acc_s_d = r2_s;
          acc_c_d = r2_c;
          if (in_last) begin
            state_d = ST_RESOLVE;
            idx_d   = '0;
            cy_d    = 1'b0;
          end
        end
      end
      ST_RESOLVE: begin
        res_d[ch_base +: K] = ch_sum[K-1:0];
        if (idx_q == LAST_IDX) begin
          // The carry out of the top chunk falls outside mod 2^W and is dropped.
          state_d = ST_OUT;
          cy_d    = 1'b0;
        end else begin
          idx_d = idx_q + IW'(1);
          cy_d  = ch_sum[K];
        end
      end
      ST_OUT: begin
        if (out_rdy) begin
          state_d = ST_ACC;
          acc_s_d = '0;
          acc_c_d = '0;
          res_d   = '0;
          idx_d   = '0;
          cy_d    = 1'b0;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_ACC;
      acc_s_q <= '0;
      acc_c_q <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_s_q <= acc_s_d;
      acc_c_q <= acc_c_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
    end
  end

  assign in_rdy  = (state_q == ST_ACC);
  assign out_vld = (state_q == ST_OUT);
  assign busy    = (state_q != ST_ACC);
  assign out_sum = res_q;

endmodule

// File: tb/tb_libv_csa_acc.sv
// tb/tb_libv_csa_acc.sv - directed and random checks of libv_csa_acc
// Inputs change and outputs are sampled on the falling edge.
module tb_libv_csa_acc;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        in_vld, in_last, in_rdy, out_vld, out_rdy, busy;
  logic [31:0] in_s, in_c, out_sum;

  logic        x_in_vld, x_in_last, x_in_rdy, x_out_vld, x_out_rdy, x_busy;
  logic [15:0] x_in_s, x_in_c, x_out_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  libv_csa_acc #(.W(32), .K(8)) dut (
    .clk(clk), .arst_n(arst_n), .in_vld(in_vld), .in_s(in_s), .in_c(in_c),
    .in_last(in_last), .in_rdy(in_rdy), .out_vld(out_vld), .out_sum(out_sum),
    .out_rdy(out_rdy), .busy(busy)
  );

  libv_csa_acc #(.W(16), .K(4)) dut16 (
    .clk(clk), .arst_n(arst_n), .in_vld(x_in_vld), .in_s(x_in_s), .in_c(x_in_c),
    .in_last(x_in_last), .in_rdy(x_in_rdy), .out_vld(x_out_vld), .out_sum(x_out_sum),
    .out_rdy(x_out_rdy), .busy(x_busy)
  );

  // Call right after a falling edge; returns at the falling edge after acceptance.
  task automatic drive_beat(input logic [31:0] s, input logic [31:0] c, input logic last);
    int n;
    n = 0;
    in_vld = 1'b1; in_s = s; in_c = c; in_last = last;
    while (!in_rdy && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!in_rdy) begin
      checks++; errors++;
      $display("FAIL beat_timeout in_rdy=%b after %0d cycles, required 1", in_rdy, n);
    end
    @(negedge clk);
    in_vld = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_vld && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!out_vld) begin
      checks++; errors++;
      $display("FAIL out_timeout out_vld=%b after %0d cycles, required 1", out_vld, n);
    end
  endtask

  task automatic take_out();
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy got %b want 1", in_rdy); end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld got %b want 0", out_vld); end
    checks++; if (out_sum !== 32'h0) begin errors++; $display("FAIL reset_out_sum got %h want 0", out_sum); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (x_out_sum !== 16'h0) begin errors++; $display("FAIL reset_w16_out_sum got %h want 0", x_out_sum); end
    arst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_chunk_carry();
    int n;
    drive_beat(32'h00FF_FFFF, 32'h0000_0001, 1'b1);
    checks++; if (busy !== 1'b1 || out_vld !== 1'b0) begin
      errors++; $display("FAIL chunk_resolving busy=%b out_vld=%b want 1/0", busy, out_vld);
    end
    wait_out(n);
    checks++; if (n != 4) begin errors++; $display("FAIL chunk_latency got %0d want 4", n); end
    checks++; if (out_sum !== 32'h0100_0000) begin errors++; $display("FAIL chunk_sum got %h want 01000000", out_sum); end
    take_out();
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] s_v [3];
    logic [31:0] c_v [3];
    s_v[0] = 32'h5;  c_v[0] = 32'h3;
    s_v[1] = 32'h10; c_v[1] = 32'h0;
    s_v[2] = 32'hFFFF_FFFF; c_v[2] = 32'h1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL b2b_in_rdy beat %0d got %b want 1", i, in_rdy); end
      drive_beat(s_v[i], c_v[i], i == 2);
    end
    wait_out(n);
    checks++; if (out_sum !== 32'h18) begin errors++; $display("FAIL b2b_sum got %h want 00000018", out_sum); end
    take_out();
  endtask

  task automatic test_backpressure();
    int n;
    drive_beat(32'h1234_5678, 32'h1111_1111, 1'b1);
    wait_out(n);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_vld !== 1'b1 || out_sum !== 32'h2345_6789 || in_rdy !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold cycle %0d vld=%b sum=%h rdy=%b busy=%b want 1/23456789/0/1",
                 i, out_vld, out_sum, in_rdy, busy);
      end
      @(negedge clk);
    end
    take_out();
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL release_in_rdy got %b want 1", in_rdy); end
    checks++; if (out_vld !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL release_state out_vld=%b busy=%b want 0/0", out_vld, busy);
    end
    checks++; if (out_sum !== 32'h0) begin errors++; $display("FAIL release_clear got %h want 0", out_sum); end
    drive_beat(32'h1, 32'h1, 1'b1);
    wait_out(n);
    checks++; if (out_sum !== 32'h2) begin errors++; $display("FAIL followup_sum got %h want 00000002", out_sum); end
    take_out();
  endtask

  task automatic test_reset_mid_resolve();
    int n;
    drive_beat(32'h0000_DEAD, 32'h0000_BEEF, 1'b1);
    repeat (2) @(negedge clk);
    arst_n = 1'b0;
    #1;
    checks++; if (in_rdy !== 1'b1 || out_vld !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_flags rdy=%b vld=%b busy=%b want 1/0/0", in_rdy, out_vld, busy);
    end
    checks++; if (out_sum !== 32'h0) begin errors++; $display("FAIL midreset_sum got %h want 0", out_sum); end
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    drive_beat(32'hA, 32'h5, 1'b1);
    wait_out(n);
    checks++; if (out_sum !== 32'hF) begin errors++; $display("FAIL midreset_next got %h want 0000000f", out_sum); end
    take_out();
  endtask

  task automatic test_stalled_input();
    int n;
    drive_beat(32'h100, 32'h200, 1'b0);
    repeat (3) @(negedge clk);
    drive_beat(32'h3000, 32'h4, 1'b0);
    @(negedge clk);
    drive_beat(32'h5, 32'h6, 1'b1);
    in_vld = 1'b1; in_s = 32'hBAD0_BAD0; in_c = 32'h0BAD_0BAD; in_last = 1'b1;
    n = 0;
    while (!out_vld && n < 64) begin
      checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL busy_in_rdy got %b want 0", in_rdy); end
      @(negedge clk);
      n++;
    end
    checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL stalled_out_vld got %b want 1", out_vld); end
    checks++; if (out_sum !== 32'h330F) begin errors++; $display("FAIL stalled_sum got %h want 0000330f", out_sum); end
    in_vld = 1'b0; in_last = 1'b0;
    take_out();
    drive_beat(32'h7, 32'h8, 1'b1);
    wait_out(n);
    checks++; if (out_sum !== 32'hF) begin errors++; $display("FAIL stalled_next got %h want 0000000f", out_sum); end
    take_out();
  endtask

  task automatic test_random();
    int n, nb;
    logic [31:0] s, c, gold;
    for (int b = 0; b < 1000; b++) begin
      nb = $urandom_range(1, 16);
      gold = 32'h0;
      for (int i = 0; i < nb; i++) begin
        s = $urandom;
        c = $urandom;
        gold = gold + s + c;
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        drive_beat(s, c, i == nb - 1);
      end
      wait_out(n);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      checks++; if (out_sum !== gold) begin
        errors++; $display("FAIL random_sum burst %0d got %h want %h", b, out_sum, gold);
      end
      take_out();
    end
  endtask

  task automatic test_w16();
    int n;
    @(negedge clk);
    x_in_vld = 1'b1; x_in_s = 16'h0FFF; x_in_c = 16'h0001; x_in_last = 1'b1;
    checks++; if (x_in_rdy !== 1'b1) begin errors++; $display("FAIL w16_in_rdy got %b want 1", x_in_rdy); end
    @(negedge clk);
    x_in_vld = 1'b0; x_in_last = 1'b0;
    n = 0;
    while (!x_out_vld && n < 64) begin @(negedge clk); n++; end
    checks++; if (n != 4) begin errors++; $display("FAIL w16_latency got %0d want 4", n); end
    checks++; if (x_out_sum !== 16'h1000) begin errors++; $display("FAIL w16_sum got %h want 1000", x_out_sum); end
    x_out_rdy = 1'b1; @(negedge clk); x_out_rdy = 1'b0;
    x_in_vld = 1'b1; x_in_s = 16'hFFFF; x_in_c = 16'h0003; x_in_last = 1'b0;
    @(negedge clk);
    x_in_s = 16'h8000; x_in_c = 16'h8000; x_in_last = 1'b1;
    @(negedge clk);
    x_in_vld = 1'b0; x_in_last = 1'b0;
    n = 0;
    while (!x_out_vld && n < 64) begin @(negedge clk); n++; end
    checks++; if (x_out_sum !== 16'h0002) begin errors++; $display("FAIL w16_wrap got %h want 0002", x_out_sum); end
    x_out_rdy = 1'b1; @(negedge clk); x_out_rdy = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n = 1'b0;
    in_vld = 1'b0; in_last = 1'b0; in_s = '0; in_c = '0; out_rdy = 1'b0;
    x_in_vld = 1'b0; x_in_last = 1'b0; x_in_s = '0; x_in_c = '0; x_out_rdy = 1'b0;
    test_reset();
    test_chunk_carry();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_resolve();
    test_stalled_input();
    test_w16();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/libv_csa_acc.md
# libv_csa_acc

Carry-save burst accumulator that sits directly downstream of the CSA reduction network. Each beat carries a redundant (sum, carry) word pair from the CSA. The block folds these pairs into a carry-save accumulator without propagating carries. When a burst's last beat arrives, it resolves the accumulator to binary with a chunked, multi-cycle carry-propagate adder. The final binary total is presented on a valid/ready output.

## Interface

Parameters:
- W, 32: word width in bits; must equal the upstream CSA W.
- K, 8: bits resolved per cycle in the carry-propagate phase; W % K == 0 is required (elaboration-time assertion).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- arst_n  in  1  reset, asynchronous assert, active-low; all state cleared while low.
- in_vld  in  1  input beat valid.
- in_s  in  W  CSA save word (upstream s_w).
- in_c  in  W  CSA carry word (upstream c_w).
- in_last  in  1  marks the final beat of a burst.
- in_rdy  out  1  block accepts a beat this cycle.
- out_vld  out  1  resolved total valid.
- out_sum  out  W  resolved total, equal to the sum of all in_s and in_c in the burst, mod 2^W.
- out_rdy  in  1  consumer accepts out_sum.
- busy  out  1  high in RESOLVE or OUT.

## Operation

- State machine with three states: ACC, RESOLVE, OUT. Reset state is ACC.
- in_rdy = (state == ACC). out_vld = (state == OUT). busy = (state != ACC). All three are decoded from the state register, with no combinational path from inputs.
- ACC behaviour:
  - A beat is accepted when in_vld and in_rdy are both high.
  - On acceptance, a 4:2 compressor (two cascaded 3:2 rows) reduces {acc_s, acc_c, in_s, in_c} to a new {acc_s, acc_c}.
  - In each row the carry is shifted left by 1 and the MSB carry-out is discarded, so arithmetic is mod 2^W.
  - acc_s and acc_c are 0 at the start of every burst.
- Accepting a beat with in_last set moves the state to RESOLVE and sets chunk index idx = 0 and carry register cy = 0.
- RESOLVE behaviour:
  - Each cycle computes {cy', r} = acc_s[idx*K +: K] + acc_c[idx*K +: K] + cy.
  - r is written to res[idx*K +: K], cy takes cy', and idx increments.
  - After chunk W/K-1 the state moves to OUT, and the final cy is discarded.
  - acc_s and acc_c are held during RESOLVE.
- OUT behaviour:
  - out_sum = res, held stable while out_vld is high and out_rdy is low.
  - When out_vld and out_rdy are both high, the state moves to ACC and acc_s, acc_c, res, idx and cy are cleared.
- in_vld is ignored outside ACC, and no beats are accepted. Upstream must hold the beat, per valid/ready rules.
- A single-beat burst (in_last on the first beat) is legal.
- Beats with in_vld low in ACC leave all state unchanged.
- Reset mid-operation: any state returns to ACC with all registers at 0. A partially accumulated burst is lost, and no out_vld pulse occurs.

## Timing

- Reset values:
  - in_rdy = 1, out_vld = 0, out_sum = 0, busy = 0.
  - Internally, acc_s = acc_c = res = 0, idx = 0, cy = 0.
- Throughput in ACC: one beat per cycle.
- Latency: if the last beat is accepted at edge E, out_vld rises after edge E + W/K. That is 4 cycles for the defaults.
- After the output handshake at edge H, in_rdy is high in the cycle following H. There is no same-cycle bypass, so the minimum burst-to-burst gap is W/K + 1 cycles with no input accepted.
- out_sum changes only on the RESOLVE-chunk edges and the clear at H.
- idx width is $clog2(W/K), with a minimum of 1 bit. idx does not wrap inside RESOLVE.

## Test plan

- Single beat, carry across a chunk boundary: in_s=0x00FF_FFFF, in_c=0x0000_0001, in_last=1 → out_vld exactly 4 cycles after acceptance, out_sum=0x0100_0000.
- Three-beat burst with wrap: beats (0x5, 0x3), (0x10, 0x0), (0xFFFF_FFFF, 0x1, last) → out_sum=0x0000_0018. in_rdy is high for all 3 consecutive beats.
- Backpressure: out_rdy held low 5 cycles after out_vld rises → out_vld=1, out_sum constant, in_rdy=0, busy=1 for the whole stall. Release → in_rdy=1 the next cycle. A follow-up burst (0x1, 0x1, last) yields 0x2, proving the accumulator clears between bursts.
- Reset mid-RESOLVE: assert arst_n low at idx=2 → in_rdy=1, out_vld=0, out_sum=0 immediately. The next burst (0xA, 0x5, last) yields 0xF.
- Stalled input: in_vld low for random gaps within a burst, and in_vld high while busy → result unaffected, and no beat is accepted while in_rdy=0.
- Random: 1000 bursts of 1–16 random (s, c) pairs with random out_rdy, plus a W=16, K=4 build → every out_sum matches the golden sum of all words mod 2^W.
